line_frame_streamer: RTL and testbench

- Synthesizable frame source that replaces host-driven pixel feeding into the line-buffered spatial filter.
- Reads a raster frame from a synchronous pixel memory and streams it over a valid/ready pixel interface.
- Primes the filter with PRIME_LINES lines, then sends one line per filter line-request (interrupt) rising edge, then sends PAD_LINES padding lines to flush the window.
- Generalised in pixel width, frame geometry, prime depth and pad count. Adds backpressure support and queuing of line requests.

---
 rtl/line_frame_streamer_pkg.sv | 29 ++
 rtl/line_frame_streamer_skid.sv | 70 +++++++
 rtl/line_frame_streamer.sv | 220 ++++++++++++++++++++++
 tb/tb_line_frame_streamer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_frame_streamer_pkg.sv
// ============================================================================
// Module   : line_stream_pkg
// Brief    : Shared types and helpers for the line frame streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_stream_pkg;

  // Frame sequencing states of the streamer
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    WAIT  = 3'd2,
    LINE  = 3'd3,
    PAD   = 3'd4,
    FIN   = 3'd5
  } streamState_t;

  // Bits needed to address every pixel of a width x height raster
  function automatic int addrWidth(input int width, input int height);
    int n;
    n = width * height;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_frame_streamer_skid.sv
// ============================================================================
// Module   : stream_skid_buf
// Brief    : 2-entry valid/ready buffer with an empty-bypass path. It absorbs
//            the memory read latency and reports whether a read issued this
//            cycle is guaranteed a free slot when its data arrives.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buf #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inValid,
  input  logic [PIX_W-1:0] i_inData,
  input  logic             i_inFlight,
  output logic             o_outValid,
  output logic [PIX_W-1:0] o_outData,
  input  logic             i_outReady,
  output logic             o_slotFree,
  output logic             o_lastOne
);

  logic [1:0]       r_count;
  logic [PIX_W-1:0] r_head;
  logic [PIX_W-1:0] r_tail;
  logic             w_pop;
  logic [1:0]       w_countNext;

  // Output comes from the head entry, or straight from the input when empty
  always_comb begin
    o_outValid  = (r_count != 2'd0) || i_inValid;
    o_outData   = (r_count != 2'd0) ? r_head : (i_inValid ? i_inData : '0);
    w_pop       = o_outValid && i_outReady;
    w_countNext = r_count + {1'b0, i_inValid} - {1'b0, w_pop};
    // A read issued now lands after one more cycle with no guaranteed pop
    o_slotFree  = ({1'b0, w_countNext} + {2'b00, i_inFlight}) <= 3'd1;
    o_lastOne   = (r_count + {1'b0, i_inValid}) == 2'd1;
  end

  // Storage update: head is the oldest pixel, tail the second oldest
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_countNext;
      case (r_count)
        2'd0: begin
          if (i_inValid && !w_pop) r_head <= i_inData;
        end
        2'd1: begin
          if (i_inValid && w_pop)       r_head <= i_inData;
          else if (i_inValid && !w_pop) r_tail <= i_inData;
        end
        default: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (i_inValid) r_tail <= i_inData;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_frame_streamer.sv
// ============================================================================
// Module   : line_frame_streamer
// Brief    : Streams a raster frame from synchronous pixel memory into a
//            line-buffered filter: prime lines, one line per request edge,
//            then padding lines to flush the filter window.
//            Build option STREAMER_PAD_REPLICATE_EN: pad lines re-read the
//            last image line instead of emitting zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_frame_streamer
  import line_stream_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int REQ_CNT_W   = 2
) (
  input  logic                                         axi_clk,
  input  logic                                         axi_reset,
  input  logic                                         i_start,
  output logic                                         o_busy,
  output logic                                         o_done,
  output logic                                         o_rd_en,
  output logic [addrWidth(IMG_WIDTH, IMG_HEIGHT)-1:0]  o_rd_addr,
  input  logic [PIX_W-1:0]                             i_rd_data,
  output logic                                         o_data_valid,
  output logic [PIX_W-1:0]                             o_data,
  input  logic                                         i_data_ready,
  input  logic                                         i_intr
);

  localparam int ADDR_W = addrWidth(IMG_WIDTH, IMG_HEIGHT);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int LINE_W = $clog2(IMG_HEIGHT + PAD_LINES + 2);

  localparam logic [CNT_W-1:0]     c_PRIME_PIX = CNT_W'(PRIME_LINES * IMG_WIDTH);
  localparam logic [CNT_W-1:0]     c_LINE_PIX  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0]     c_REPL_BASE = CNT_W'((IMG_HEIGHT - 1) * IMG_WIDTH);
  localparam logic [LINE_W-1:0]    c_IMG_LEFT  = LINE_W'(IMG_HEIGHT - PRIME_LINES);
  localparam logic [LINE_W-1:0]    c_PAD_LEFT  = LINE_W'(PAD_LINES);
  localparam logic [REQ_CNT_W-1:0] c_PEND_MAX  = '1;
`ifdef STREAMER_PAD_REPLICATE_EN
  localparam logic c_PAD_READS = 1'b1;
`else
  localparam logic c_PAD_READS = 1'b0;
`endif

  generate
    if (PRIME_LINES > IMG_HEIGHT || IMG_WIDTH < 2) begin : g_badParams
      $error("line_frame_streamer: PRIME_LINES must not exceed IMG_HEIGHT and IMG_WIDTH must be >= 2");
    end
  endgenerate

  streamState_t         r_state;
  logic [CNT_W-1:0]     r_remain;
  logic [CNT_W-1:0]     r_addrCnt;
  logic [ADDR_W-1:0]    r_rdAddr;
  logic [LINE_W-1:0]    r_imgLeft;
  logic [LINE_W-1:0]    r_padLeft;
  logic [REQ_CNT_W-1:0] r_pending;
  logic                 r_busy;
  logic                 r_issue;
  logic                 r_issuePad;
  logic                 r_inValid;
  logic                 r_inPad;
  logic                 r_intrQ;

  logic             w_slotFree;
  logic             w_lastOne;
  logic             w_pop;
  logic             w_edge;
  logic             w_issuing;
  logic             w_phaseEnd;
  logic             w_decide;
  logic             w_enterLine;
  logic             w_enterPad;
  logic             w_enterFin;
  logic [PIX_W-1:0] w_inData;

  // Phase bookkeeping: the next phase is chosen on the edge that issues the
  // last pixel of the current one, so consecutive lines stream gap-free
  always_comb begin
    w_pop       = o_data_valid && i_data_ready;
    w_edge      = i_intr && !r_intrQ && (r_state != IDLE);
    w_issuing   = ((r_state == PRIME) || (r_state == LINE) || (r_state == PAD)) && w_slotFree;
    w_phaseEnd  = w_issuing && (r_remain == CNT_W'(1));
    w_decide    = w_phaseEnd || (r_state == WAIT);
    w_enterLine = w_decide && (r_imgLeft != '0) && (r_pending != '0);
    w_enterPad  = w_decide && (r_imgLeft == '0) && (r_padLeft != '0) && (r_pending != '0);
    w_enterFin  = w_decide && (r_imgLeft == '0) && (r_padLeft == '0);
    w_inData    = r_inPad ? '0 : i_rd_data;
  end

  // Request edge detector and saturating pending-request counter
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_intrQ   <= 1'b0;
      r_pending <= '0;
    end else begin
      r_intrQ <= i_intr;
      if (r_state == IDLE) begin
        r_pending <= '0;
      end else if (w_edge && !(w_enterLine || w_enterPad)) begin
        if (r_pending != c_PEND_MAX) r_pending <= r_pending + REQ_CNT_W'(1);
      end else if (!w_edge && (w_enterLine || w_enterPad)) begin
        r_pending <= r_pending - REQ_CNT_W'(1);
      end
    end
  end

  // Track issued reads/pads so their data enters the buffer one cycle later
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_inValid <= 1'b0;
      r_inPad   <= 1'b0;
    end else begin
      r_inValid <= r_issue;
      r_inPad   <= r_issuePad;
    end
  end

  // Frame sequencer: issues reads or pad pixels and steps through the phases
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_issue    <= 1'b0;
      r_issuePad <= 1'b0;
      r_rdAddr   <= '0;
      r_addrCnt  <= '0;
      r_remain   <= '0;
      r_imgLeft  <= '0;
      r_padLeft  <= '0;
    end else begin
      r_issue    <= 1'b0;
      r_issuePad <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_busy    <= 1'b1;
            r_imgLeft <= c_IMG_LEFT;
            r_padLeft <= c_PAD_LEFT;
            r_addrCnt <= '0;
            if (PRIME_LINES > 0) begin
              // First read goes out on the accepting edge to meet the latency
              r_state   <= PRIME;
              r_issue   <= 1'b1;
              r_rdAddr  <= '0;
              r_addrCnt <= CNT_W'(1);
              r_remain  <= c_PRIME_PIX - CNT_W'(1);
            end else begin
              r_state <= WAIT;
            end
          end
        end
        PRIME, LINE, PAD: begin
          if (w_slotFree) begin
            r_issue  <= 1'b1;
            r_remain <= r_remain - CNT_W'(1);
            if ((r_state == PAD) && !c_PAD_READS) begin
              r_issuePad <= 1'b1;
            end else begin
              r_rdAddr  <= r_addrCnt[ADDR_W-1:0];
              r_addrCnt <= r_addrCnt + CNT_W'(1);
            end
          end
        end
        FIN: begin
          if (!r_issue && w_lastOne && w_pop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
      // Phase transitions override the per-state defaults above
      if (w_enterLine) begin
        r_state   <= LINE;
        r_remain  <= c_LINE_PIX;
        r_imgLeft <= r_imgLeft - LINE_W'(1);
      end else if (w_enterPad) begin
        r_state   <= PAD;
        r_remain  <= c_LINE_PIX;
        r_padLeft <= r_padLeft - LINE_W'(1);
        if (c_PAD_READS) r_addrCnt <= c_REPL_BASE;
      end else if (w_enterFin) begin
        r_state <= FIN;
      end else if (w_phaseEnd) begin
        r_state <= WAIT;
      end
    end
  end

  stream_skid_buf #(
    .PIX_W (PIX_W)
  ) u_skid (
    .clk        (axi_clk),
    .rst        (axi_reset),
    .i_inValid  (r_inValid),
    .i_inData   (w_inData),
    .i_inFlight (r_issue),
    .o_outValid (o_data_valid),
    .o_outData  (o_data),
    .i_outReady (i_data_ready),
    .o_slotFree (w_slotFree),
    .o_lastOne  (w_lastOne)
  );

  assign o_busy    = r_busy;
  assign o_rd_en   = r_issue && !r_issuePad;
  assign o_rd_addr = r_rdAddr;
  assign o_done    = (r_state == FIN) && !r_issue && w_lastOne && w_pop;

endmodule

`default_nettype wire

// File: tb/tb_line_frame_streamer.sv
// ============================================================================
// Module   : tb_line_frame_streamer
// Brief    : Directed self-checking bench for line_frame_streamer
//            (8x6 frame, 4 prime lines, 2 pad lines). Honours
//            STREAMER_PAD_REPLICATE_EN for pad pixel/address expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_line_frame_streamer;

  localparam int PIX_W = 8;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int NIMG  = W * H;
  localparam int NPIX  = NIMG + 2 * W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             intr = 1'b0;
  logic             ready = 1'b1;
  logic             randMode = 1'b0;
  logic             busy, done, rdEn, dv;
  logic [5:0]       rdAddr;
  logic [PIX_W-1:0] memData = '0;
  logic [PIX_W-1:0] data;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int got[$];
  int gotCyc[$];
  int addrQ[$];
  int doneCnt = 0, doneIdx = 0;
  logic doneAcc = 1'b0, busyAtDone = 1'b0;
  logic stallPrev = 1'b0;
  logic [PIX_W-1:0] prevData = '0;

  line_frame_streamer #(
    .PIX_W(PIX_W), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .PRIME_LINES(4), .PAD_LINES(2), .REQ_CNT_W(2)
  ) dut (
    .axi_clk(clk), .axi_reset(rst), .i_start(start), .o_busy(busy),
    .o_done(done), .o_rd_en(rdEn), .o_rd_addr(rdAddr), .i_rd_data(memData),
    .o_data_valid(dv), .o_data(data), .i_data_ready(ready), .i_intr(intr)
  );

  always #5 clk = ~clk;

  // Memory model: data = address, one cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdEn) memData <= 8'(rdAddr);
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expPix(input int i);
`ifdef STREAMER_PAD_REPLICATE_EN
    return (i < NIMG) ? i : (NIMG - W) + ((i - NIMG) % W);
`else
    return (i < NIMG) ? i : 0;
`endif
  endfunction

  // Monitor: accepted pixels, issued addresses, done pulse, stall stability
  always @(negedge clk) begin
    if (rst) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) checkVal("stall_hold", {23'd0, dv, data}, {23'd0, 1'b1, prevData});
      if (dv && ready) begin
        got.push_back(int'(data));
        gotCyc.push_back(cyc);
      end
      if (rdEn) addrQ.push_back(int'(rdAddr));
      if (done) begin
        doneCnt++;
        doneIdx    = got.size();
        doneAcc    = dv && ready;
        busyAtDone = busy;
      end
      stallPrev = dv && !ready;
      prevData  = data;
    end
  end

  // Ready driver: constant high or random 50%
  initial begin
    forever begin
      @(posedge clk); #1;
      ready = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic toNeg();
    @(negedge clk); #2;
  endtask

  task automatic toPos();
    @(posedge clk); #1;
  endtask

  task automatic clearLogs();
    got.delete(); gotCyc.delete(); addrQ.delete();
    doneCnt = 0; doneIdx = 0; doneAcc = 1'b0; busyAtDone = 1'b0;
  endtask

  task automatic doReset();
    toPos();
    rst = 1'b1;
    repeat (3) toPos();
    rst = 1'b0;
    clearLogs();
  endtask

  task automatic pulseStart();
    toPos();
    start = 1'b1;
    toPos();
    start = 1'b0;
  endtask

  task automatic pulseIntr();
    toPos();
    intr = 1'b1;
    repeat (2) toPos();
    intr = 1'b0;
    repeat (2) toPos();
  endtask

  task automatic waitPix(input int n, input int limit);
    int k = 0;
    while (got.size() < n && k < limit) begin toNeg(); k++; end
    if (got.size() < n) checkVal("timeout_pix", got.size(), n);
  endtask

  task automatic waitDone(input int limit);
    int k = 0;
    while (doneCnt == 0 && k < limit) begin toNeg(); k++; end
    if (doneCnt == 0) checkVal("timeout_done", 0, 1);
  endtask

  task automatic checkSeq(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (got.size() <= i) begin
        checkVal({tag, "_missing"}, got.size(), i + 1);
        break;
      end
      checkVal(tag, got[i], expPix(i));
    end
  endtask

  initial begin
    // ---- Reset state ----
    doReset();
    toNeg();
    checkVal("rst_busy", busy, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_rden", rdEn, 0);
    checkVal("rst_valid", dv, 0);
    checkVal("rst_addr", rdAddr, 0);
    checkVal("rst_data", data, 0);

    // ---- 1: prime lines, latency and back-to-back ----
    pulseStart();
    toNeg();
    checkVal("lat_rden_c1", rdEn, 1);
    checkVal("lat_addr_c1", rdAddr, 0);
    checkVal("lat_valid_c1", dv, 0);
    checkVal("lat_busy_c1", busy, 1);
    toNeg();
    checkVal("lat_valid_c2", dv, 1);
    checkVal("lat_data_c2", data, 0);
    waitPix(32, 60);
    repeat (10) toNeg();
    checkVal("prime_count", got.size(), 32);
    checkVal("prime_idle_valid", dv, 0);
    checkVal("prime_idle_busy", busy, 1);
    checkSeq("prime_pix", 0, 31);
    if (gotCyc.size() >= 32) checkVal("prime_b2b", gotCyc[31] - gotCyc[0], 31);

    // ---- 2: requested lines, pad lines, done ----
    pulseIntr();
    waitPix(40, 40);
    repeat (5) toNeg();
    checkVal("line1_count", got.size(), 40);
    pulseIntr();
    waitPix(48, 40);
    pulseIntr();
    pulseIntr();
    waitDone(100);
    checkVal("done_count", doneCnt, 1);
    checkVal("done_idx", doneIdx, NPIX);
    checkVal("done_with_accept", doneAcc, 1);
    checkVal("done_busy", busyAtDone, 1);
    toNeg();
    checkVal("busy_after_done", busy, 0);
    checkVal("total_pix", got.size(), NPIX);
    checkSeq("frame_pix", 32, NPIX - 1);
`ifdef STREAMER_PAD_REPLICATE_EN
    checkVal("addr_count", addrQ.size(), NPIX);
`else
    checkVal("addr_count", addrQ.size(), NIMG);
`endif
    for (int i = 0; i < addrQ.size() && i < NPIX; i++)
      checkVal("rd_addr", addrQ[i], (i < NIMG) ? i : (NIMG - W) + ((i - NIMG) % W));

    // ---- 3: random backpressure ----
    doReset();
    randMode = 1'b1;
    pulseStart();
    waitPix(24, 300);
    pulseIntr();
    pulseIntr();
    waitPix(40, 300);
    pulseIntr();
    pulseIntr();
    waitDone(600);
    randMode = 1'b0;
    repeat (3) toNeg();
    checkVal("bp_total", got.size(), NPIX);
    checkSeq("bp_pix", 0, NPIX - 1);

    // ---- 4: requests queued during prime ----
    doReset();
    pulseStart();
    pulseIntr();
    pulseIntr();
    pulseIntr();
    waitPix(56, 150);
    repeat (15) toNeg();
    checkVal("queue_count", got.size(), 56);
    checkVal("queue_busy", busy, 1);
    if (gotCyc.size() >= 56) checkVal("queue_b2b", gotCyc[55] - gotCyc[0], 55);
    pulseIntr();
    waitDone(100);
    checkVal("queue_total", got.size(), NPIX);
    checkSeq("queue_pix", 0, NPIX - 1);

    // ---- 5: reset mid-frame ----
    doReset();
    pulseStart();
    begin
      int k = 0;
      toNeg();
      while (!(dv && data == 8'd20) && k < 60) begin toNeg(); k++; end
      checkVal("mid_reach20", data, 20);
    end
    rst = 1'b1;
    toPos();
    rst = 1'b0;
    toNeg();
    checkVal("mid_valid", dv, 0);
    checkVal("mid_busy", busy, 0);
    checkVal("mid_rden", rdEn, 0);
    clearLogs();
    pulseStart();
    waitPix(32, 80);
    checkSeq("restart_pix", 0, 31);
    doReset();

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
